// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Provides the round count, the 128-bit block type, the key-schedule FSM state
// type and the round-constant lookup.
package aes_pkg;

   localparam int unsigned NR    = 10;
   localparam int unsigned BLK_W = 128;

   typedef logic [BLK_W-1:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2,
      STREAM = 2'd3
   } aes_ks_state_t;

   // Rcon[1..10]; other indices never reach the datapath and return zero.
   function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Ports: data_i - input byte, data_o - substituted byte.
// Built as GF(2^8) inversion (x^254) followed by the affine transform, which
// avoids hand-maintaining a 256-entry table.
module aes_sbox (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv    = gf_inv(data_i);
      data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key schedule feeding the decryption datapath.
// Expands key_in into RK0..RK10 (one round per clock), stores them, then
// streams them RK10..RK0 over a valid/ready handshake.
// Ports:
//   clk, rst          - clock, async active-high reset
//   key_in, key_load  - cipher key and load strobe (highest priority)
//   key_ready         - all round keys present in the store
//   start_dec         - request one reverse stream (honoured only in READY)
//   rk_out, rk_idx    - current round key and its index
//   rk_valid/rk_ready - stream handshake; rk_last marks the RK0 beat
module aes_inv_key_sched #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         key_ready,
   input  logic         start_dec,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         rk_last
);

   import aes_pkg::*;

   aes_ks_state_t state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   aes_block_t    cur_q, cur_d;
   aes_block_t    store_q [0:NR];

   logic          st_we;
   logic [3:0]    st_addr;
   aes_block_t    st_wdata;

   logic          key_ready_d, rk_valid_d, rk_last_d;
   logic [3:0]    rk_idx_d;
   aes_block_t    rk_out_d;

   // Round step on the most recently written key.
   logic [31:0]   w3_rot, sub_w, t_w;
   logic [31:0]   nw0, nw1, nw2, nw3;
   aes_block_t    next_rk;

   assign w3_rot = {cur_q[23:0], cur_q[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .data_i (w3_rot[8*g +: 8]),
         .data_o (sub_w[8*g +: 8])
      );
   end

   always_comb begin
      t_w     = sub_w ^ {aes_rcon(cnt_q), 24'h000000};
      nw0     = cur_q[127:96] ^ t_w;
      nw1     = cur_q[95:64]  ^ nw0;
      nw2     = cur_q[63:32]  ^ nw1;
      nw3     = cur_q[31:0]   ^ nw2;
      next_rk = {nw0, nw1, nw2, nw3};
   end

   // Next-state, store write port and next output values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      cur_d    = cur_q;
      st_we    = 1'b0;
      st_addr  = cnt_q;
      st_wdata = next_rk;

      case (state_q)
         EXPAND: begin
            st_we = 1'b1;
            cur_d = next_rk;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(NR)) state_d = READY;
         end
         READY: begin
            if (start_dec) begin
               state_d = STREAM;
               idx_d   = 4'(NR);
            end
         end
         STREAM: begin
            if (rk_valid && rk_ready) begin
               if (idx_q == 4'd0) state_d = READY;
               else               idx_d   = idx_q - 4'd1;
            end
         end
         default: ;
      endcase

      // A load overrides whatever the current state decided.
      if (key_load) begin
         state_d  = EXPAND;
         cnt_d    = 4'd1;
         cur_d    = key_in;
         st_we    = 1'b1;
         st_addr  = 4'd0;
         st_wdata = key_in;
      end

      key_ready_d = (state_d == READY) || (state_d == STREAM);
      rk_valid_d  = (state_d == STREAM);
      rk_out_d    = '0;
      rk_idx_d    = 4'd0;
      rk_last_d   = 1'b0;
      // Store is never written while streaming, so reading at idx_d is safe.
      if (state_d == STREAM) begin
         rk_out_d  = store_q[idx_d];
         rk_idx_d  = idx_d;
         rk_last_d = (idx_d == 4'd0);
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= 4'd0;
         cur_q     <= '0;
         key_ready <= 1'b0;
         rk_valid  <= 1'b0;
         rk_last   <= 1'b0;
         rk_idx    <= 4'd0;
         rk_out    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         cur_q     <= cur_d;
         key_ready <= key_ready_d;
         rk_valid  <= rk_valid_d;
         rk_last   <= rk_last_d;
         rk_idx    <= rk_idx_d;
         rk_out    <= rk_out_d;
      end
   end

   // Round-key store; deliberately not reset.
   always_ff @(posedge clk) begin
      if (st_we) store_q[st_addr] <= st_wdata;
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 expansion vectors.
module tb_aes_inv_key_sched;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         key_ready;
   logic         start_dec;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic         rk_ready;
   logic         rk_last;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_2  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   localparam logic [127:0] A1_RK [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_inv_key_sched #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_load  (key_load),
      .key_ready (key_ready),
      .start_dec (start_dec),
      .rk_out    (rk_out),
      .rk_idx    (rk_idx),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_last   (rk_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (10) tick();
   endtask

   task automatic start_stream();
      start_dec = 1'b1;
      tick();
      start_dec = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_total++;
      if ({key_ready, rk_valid, rk_last} !== 3'b000 || rk_idx !== 4'd0 || rk_out !== 128'h0)
         $display("FAIL reset_values ready=%b valid=%b last=%b idx=%0d out=%h expected all zero",
                  key_ready, rk_valid, rk_last, rk_idx, rk_out);
      else n_pass++;
      #7 rst = 1'b0;
      tick();
   endtask

   task automatic test_fips_a1();
      key_in   = KEY_A1;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (9) tick();
      n_total++;
      if (key_ready !== 1'b0 || rk_valid !== 1'b0)
         $display("FAIL a1_not_ready_t9 ready=%b valid=%b expected 0 0", key_ready, rk_valid);
      else n_pass++;
      tick();
      n_total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0)
         $display("FAIL a1_ready_t10 ready=%b valid=%b expected 1 0", key_ready, rk_valid);
      else n_pass++;
      rk_ready = 1'b1;
      start_stream();
      for (int i = 10; i >= 0; i--) begin
         n_total++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== A1_RK[i] || rk_last !== (i == 0))
            $display("FAIL a1_beat%0d valid=%b idx=%0d out=%h last=%b expected idx=%0d out=%h",
                     i, rk_valid, rk_idx, rk_out, rk_last, i, A1_RK[i]);
         else n_pass++;
         tick();
      end
      n_total++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_last !== 1'b0)
         $display("FAIL a1_stream_end valid=%b ready=%b last=%b expected 0 1 0",
                  rk_valid, key_ready, rk_last);
      else n_pass++;
   endtask

   task automatic test_second_key();
      rk_ready = 1'b1;
      load_key(KEY_2);
      start_stream();
      n_total++;
      if (rk_idx !== 4'd10 || rk_out !== K2_RK10)
         $display("FAIL k2_first_beat idx=%0d out=%h expected 10 %h", rk_idx, rk_out, K2_RK10);
      else n_pass++;
      for (int i = 10; i >= 0; i--) begin
         n_total++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i))
            $display("FAIL k2_cycle%0d valid=%b idx=%0d expected 1 %0d", i, rk_valid, rk_idx, i);
         else n_pass++;
         if (i == 1) begin
            n_total++;
            if (rk_out !== K2_RK1) $display("FAIL k2_rk1 out=%h expected %h", rk_out, K2_RK1);
            else n_pass++;
         end
         if (i == 0) begin
            n_total++;
            if (rk_out !== KEY_2 || rk_last !== 1'b1)
               $display("FAIL k2_rk0 out=%h last=%b expected %h 1", rk_out, rk_last, KEY_2);
            else n_pass++;
         end
         tick();
      end
      n_total++;
      if (rk_valid !== 1'b0) $display("FAIL k2_after_11 valid=%b expected 0", rk_valid);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      int           exp_idx;
      int           transfers;
      logic         stalled;
      logic [127:0] p_out;
      logic [3:0]   p_idx;
      logic         p_last;
      logic         r;
      rk_ready  = 1'b0;
      load_key(KEY_A1);
      start_stream();
      exp_idx   = 10;
      transfers = 0;
      stalled   = 1'b0;
      p_out = '0; p_idx = '0; p_last = 1'b0;
      for (int cyc = 0; cyc < 200 && rk_valid; cyc++) begin
         if (stalled) begin
            n_total++;
            if (rk_out !== p_out || rk_idx !== p_idx || rk_last !== p_last)
               $display("FAIL bp_hold idx=%0d out=%h last=%b expected %0d %h %b",
                        rk_idx, rk_out, rk_last, p_idx, p_out, p_last);
            else n_pass++;
         end
         r = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
         rk_ready = r;
         if (r) begin
            n_total++;
            if (exp_idx < 0 || rk_idx !== 4'(exp_idx) || rk_out !== A1_RK[exp_idx < 0 ? 0 : exp_idx]
                || rk_last !== (exp_idx == 0))
               $display("FAIL bp_transfer idx=%0d out=%h expected idx=%0d", rk_idx, rk_out, exp_idx);
            else n_pass++;
            exp_idx--;
            transfers++;
         end
         p_out = rk_out; p_idx = rk_idx; p_last = rk_last;
         stalled = !r;
         tick();
      end
      n_total++;
      if (transfers != 11 || rk_valid !== 1'b0 || key_ready !== 1'b1)
         $display("FAIL bp_count transfers=%0d valid=%b ready=%b expected 11 0 1",
                  transfers, rk_valid, key_ready);
      else n_pass++;
      rk_ready = 1'b1;
      start_stream();
      for (int i = 10; i >= 0; i--) begin
         n_total++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== A1_RK[i])
            $display("FAIL bp_replay%0d idx=%0d out=%h expected %0d %h", i, rk_idx, rk_out, i, A1_RK[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_ignored_and_abort();
      rk_ready = 1'b0;
      key_in   = KEY_A1;
      key_load = 1'b1;
      tick();
      key_load  = 1'b0;
      start_dec = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (rk_valid !== 1'b0) $display("FAIL start_in_expand%0d valid=%b expected 0", i, rk_valid);
         else n_pass++;
      end
      start_dec = 1'b0;
      repeat (7) tick();
      rk_ready = 1'b1;
      repeat (2) tick();
      n_total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0)
         $display("FAIL start_not_queued ready=%b valid=%b expected 1 0", key_ready, rk_valid);
      else n_pass++;
      rk_ready = 1'b0;
      start_stream();
      start_dec = 1'b1;
      tick();
      start_dec = 1'b0;
      n_total++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk_out !== A1_RK[10])
         $display("FAIL start_in_stream valid=%b idx=%0d out=%h expected 1 10 %h",
                  rk_valid, rk_idx, rk_out, A1_RK[10]);
      else n_pass++;
      rk_ready = 1'b1;
      tick();
      n_total++;
      if (rk_idx !== 4'd9 || rk_out !== A1_RK[9])
         $display("FAIL abort_pre idx=%0d out=%h expected 9 %h", rk_idx, rk_out, A1_RK[9]);
      else n_pass++;
      key_in   = KEY_2;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      n_total++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b0)
         $display("FAIL abort_drop valid=%b ready=%b expected 0 0", rk_valid, key_ready);
      else n_pass++;
      repeat (10) tick();
      n_total++;
      if (key_ready !== 1'b1) $display("FAIL abort_reexpand ready=%b expected 1", key_ready);
      else n_pass++;
      rk_ready = 1'b0;
      start_stream();
      n_total++;
      if (rk_idx !== 4'd10 || rk_out !== K2_RK10)
         $display("FAIL abort_new_rk10 idx=%0d out=%h expected 10 %h", rk_idx, rk_out, K2_RK10);
      else n_pass++;
   endtask

   task automatic test_load_vs_start();
      rk_ready = 1'b1;
      load_key(KEY_A1);
      key_in    = KEY_2;
      key_load  = 1'b1;
      start_dec = 1'b1;
      tick();
      key_load  = 1'b0;
      start_dec = 1'b0;
      n_total++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b0)
         $display("FAIL collide_next valid=%b ready=%b expected 0 0", rk_valid, key_ready);
      else n_pass++;
      repeat (9) tick();
      n_total++;
      if (key_ready !== 1'b0 || rk_valid !== 1'b0)
         $display("FAIL collide_t9 ready=%b valid=%b expected 0 0", key_ready, rk_valid);
      else n_pass++;
      tick();
      n_total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0)
         $display("FAIL collide_t10 ready=%b valid=%b expected 1 0", key_ready, rk_valid);
      else n_pass++;
      rk_ready = 1'b0;
      start_stream();
      n_total++;
      if (rk_idx !== 4'd10 || rk_out !== K2_RK10)
         $display("FAIL collide_rk10 idx=%0d out=%h expected 10 %h", rk_idx, rk_out, K2_RK10);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      rk_ready = 1'b0;
      key_in   = KEY_A1;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({key_ready, rk_valid, rk_last} !== 3'b000 || rk_idx !== 4'd0 || rk_out !== 128'h0)
         $display("FAIL rst_expand ready=%b valid=%b last=%b idx=%0d out=%h expected all zero",
                  key_ready, rk_valid, rk_last, rk_idx, rk_out);
      else n_pass++;
      #1 rst = 1'b0;
      tick();
      repeat (12) tick();
      n_total++;
      if (key_ready !== 1'b0 || rk_valid !== 1'b0)
         $display("FAIL rst_expand_lost ready=%b valid=%b expected 0 0", key_ready, rk_valid);
      else n_pass++;
      load_key(KEY_A1);
      start_stream();
      n_total++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk_out !== A1_RK[10])
         $display("FAIL rst_pre_stream valid=%b idx=%0d out=%h expected 1 10 %h",
                  rk_valid, rk_idx, rk_out, A1_RK[10]);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({key_ready, rk_valid, rk_last} !== 3'b000 || rk_idx !== 4'd0 || rk_out !== 128'h0)
         $display("FAIL rst_stream ready=%b valid=%b last=%b idx=%0d out=%h expected all zero",
                  key_ready, rk_valid, rk_last, rk_idx, rk_out);
      else n_pass++;
      #1 rst = 1'b0;
      tick();
      load_key(KEY_2);
      n_total++;
      if (key_ready !== 1'b1) $display("FAIL rst_reload_ready ready=%b expected 1", key_ready);
      else n_pass++;
      start_stream();
      n_total++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk_out !== K2_RK10)
         $display("FAIL rst_reload_rk10 valid=%b idx=%0d out=%h expected 1 10 %h",
                  rk_valid, rk_idx, rk_out, K2_RK10);
      else n_pass++;
   endtask

   initial begin
      rst       = 1'b1;
      key_in    = '0;
      key_load  = 1'b0;
      start_dec = 1'b0;
      rk_ready  = 1'b0;
      test_reset();
      test_fips_a1();
      test_second_key();
      test_back_pressure();
      test_ignored_and_abort();
      test_load_vs_start();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
